rf_pulse_sequencer: RTL and testbench

Trigger-driven RF pulse sequencer for the atom-interferometry rig. It produces the gate signal `rf` for the RF switch in two modes: a Mach-Zehnder sequence (π/2 – T – π – T – π/2) and a Rabi scan, which emits a single pulse whose length grows by a fixed step on every trigger. It sits between the Arduino trigger pin and the RF switch driver. Timing configuration is latched per shot, so the host can rewrite it while a sequence is running.

---
 rtl/rf_pulse_sequencer.sv | 153 +++++++++++++++
 tb/tb_rf_pulse_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/rf_pulse_sequencer.sv
// rf_pulse_sequencer: trigger-driven Mach-Zehnder / Rabi-scan RF gate sequencer (optional HOLD dead-time under RF_SEQ_HOLDOFF_EN)
module rf_pulse_sequencer #(
   parameter int CNT_W   = 24,
   parameter int SEQ_W   = 16,
   parameter int HOLDOFF = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig,
   input  logic             mode,
   input  logic [CNT_W-1:0] pi2_len,
   input  logic [CNT_W-1:0] pi_len,
   input  logic [CNT_W-1:0] gap_len,
   input  logic [CNT_W-1:0] rabi_start,
   input  logic [CNT_W-1:0] rabi_step,
   input  logic [CNT_W-1:0] rabi_max,
   input  logic             scan_clr,
   output logic             rf,
   output logic             busy,
   output logic             done,
   output logic             trig_miss,
   output logic             scan_wrap,
   output logic [CNT_W-1:0] cur_len,
   output logic [SEQ_W-1:0] seq_count
);
   localparam int HW = $clog2(HOLDOFF + 1);
   localparam int CW = CNT_W > HW ? CNT_W : HW;
   typedef enum logic [2:0] {
      IDLE, PI2_A, GAP_A, PI, GAP_B, PI2_B, RABI
`ifdef RF_SEQ_HOLDOFF_EN
      , HOLD
`endif
   } state_t;
`ifdef RF_SEQ_HOLDOFF_EN
   localparam state_t FIN_ST = HOLD;
`else
   localparam state_t FIN_ST = IDLE;
`endif
   state_t state, nxt, n_pa, n_ga, n_pi, n_gb, n_pb, n_rb;
   logic s1, s2, s3, trig_edge, idle, m, fin, wrap, started, sh_mode;
   logic [CNT_W-1:0] sh_pi2, sh_pi, sh_gap, sh_rabi, sh_start, sh_step, sh_max;
   logic [CNT_W-1:0] l_pi2, l_pi, l_gap, l_rabi, l_start, l_step, l_max;
   logic [CW-1:0] cnt, nlen;
   logic [CNT_W:0] sum;
   // synchronise trig and register its rising edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
         trig_edge <= 1'b0;
      end else begin
         s1 <= trig;
         s2 <= s1;
         s3 <= s2;
         trig_edge <= s2 & ~s3;
      end
   end
   // next phase, skipping zero-length phases, and Rabi scan arithmetic
   always_comb begin
      idle = state == IDLE;
      l_pi2 = idle ? pi2_len : sh_pi2;
      l_pi = idle ? pi_len : sh_pi;
      l_gap = idle ? gap_len : sh_gap;
      l_rabi = idle ? cur_len : sh_rabi;
      l_start = idle ? rabi_start : sh_start;
      l_step = idle ? rabi_step : sh_step;
      l_max = idle ? rabi_max : sh_max;
      m = idle ? mode : sh_mode;
      n_pb = l_pi2 != '0 ? PI2_B : FIN_ST;
      n_gb = l_gap != '0 ? GAP_B : n_pb;
      n_pi = l_pi != '0 ? PI : n_gb;
      n_ga = l_gap != '0 ? GAP_A : n_pi;
      n_pa = l_pi2 != '0 ? PI2_A : n_ga;
      n_rb = l_rabi != '0 ? RABI : FIN_ST;
      nxt = state;
      case (state)
         IDLE:  nxt = trig_edge ? (mode ? n_rb : n_pa) : IDLE;
         PI2_A: nxt = cnt == '0 ? n_ga : PI2_A;
         GAP_A: nxt = cnt == '0 ? n_pi : GAP_A;
         PI:    nxt = cnt == '0 ? n_gb : PI;
         GAP_B: nxt = cnt == '0 ? n_pb : GAP_B;
         PI2_B: nxt = cnt == '0 ? FIN_ST : PI2_B;
         RABI:  nxt = cnt == '0 ? FIN_ST : RABI;
`ifdef RF_SEQ_HOLDOFF_EN
         HOLD:  nxt = cnt == '0 ? IDLE : HOLD;
`endif
         default: nxt = IDLE;
      endcase
      fin = nxt == FIN_ST && (idle ? trig_edge : state != FIN_ST);
      nlen = (nxt == PI2_A || nxt == PI2_B) ? CW'(l_pi2) :
             nxt == PI ? CW'(l_pi) :
             (nxt == GAP_A || nxt == GAP_B) ? CW'(l_gap) :
             nxt == RABI ? CW'(l_rabi) : CW'(HOLDOFF);
      sum = {1'b0, cur_len} + {1'b0, l_step};
      wrap = sum[CNT_W] || sum > {1'b0, l_max};
   end
   // state, phase counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         rf <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         trig_miss <= 1'b0;
         seq_count <= '0;
      end else begin
         state <= nxt;
         cnt <= nxt != state ? nlen - 1'b1 : cnt - 1'b1;
         rf <= nxt == PI2_A || nxt == PI || nxt == PI2_B || nxt == RABI;
         busy <= nxt != IDLE;
         done <= fin;
         trig_miss <= trig_edge && !idle;
         seq_count <= seq_count + SEQ_W'(fin);
      end
   end
   // per-shot shadow copy of the configuration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_mode <= 1'b0;
         sh_pi2 <= '0;
         sh_pi <= '0;
         sh_gap <= '0;
         sh_rabi <= '0;
         sh_start <= '0;
         sh_step <= '0;
         sh_max <= '0;
      end else if (idle && trig_edge) begin
         sh_mode <= mode;
         sh_pi2 <= pi2_len;
         sh_pi <= pi_len;
         sh_gap <= gap_len;
         sh_rabi <= cur_len;
         sh_start <= rabi_start;
         sh_step <= rabi_step;
         sh_max <= rabi_max;
      end
   end
   // Rabi length: load after reset, clear on request, step on each Rabi completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started <= 1'b0;
         cur_len <= '0;
         scan_wrap <= 1'b0;
      end else begin
         started <= 1'b1;
         if (!started || scan_clr) cur_len <= rabi_start;
         else if (fin && m) cur_len <= wrap ? l_start : sum[CNT_W-1:0];
         scan_wrap <= started && !scan_clr && fin && m && wrap;
      end
   end
endmodule

// File: tb/tb_rf_pulse_sequencer.sv
// tb_rf_pulse_sequencer: directed self-checking bench for rf_pulse_sequencer (default build)
module tb_rf_pulse_sequencer;
   logic clk = 1'b0, rst_n = 1'b0, trig = 1'b0, mode = 1'b0, scan_clr = 1'b0;
   logic [23:0] pi2_len = '0, pi_len = '0, gap_len = '0;
   logic [23:0] rabi_start = 24'd10, rabi_step = 24'd10, rabi_max = 24'd30;
   logic rf, busy, done, trig_miss, scan_wrap;
   logic [23:0] cur_len;
   logic [15:0] seq_count;
   logic [127:0] rf_v, done_v, busy_v, miss_v, wrap_v;
   int n_cmp = 0, n_err = 0;
   rf_pulse_sequencer dut (
      .clk(clk), .rst_n(rst_n), .trig(trig), .mode(mode),
      .pi2_len(pi2_len), .pi_len(pi_len), .gap_len(gap_len),
      .rabi_start(rabi_start), .rabi_step(rabi_step), .rabi_max(rabi_max),
      .scan_clr(scan_clr), .rf(rf), .busy(busy), .done(done),
      .trig_miss(trig_miss), .scan_wrap(scan_wrap),
      .cur_len(cur_len), .seq_count(seq_count)
   );
   always #5 clk = ~clk;
   function automatic logic [127:0] rng(input int lo, input int hi);
      logic [127:0] v = '0;
      for (int i = lo; i <= hi; i++) v[i] = 1'b1;
      return v;
   endfunction
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // trigger sampled at edge 0; sample i is taken in cycle i; extra>=0 adds a second trigger
   task automatic shot(input int n, input int extra);
      rf_v = '0; done_v = '0; busy_v = '0; miss_v = '0; wrap_v = '0;
      @(negedge clk);
      trig = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rf_v[i] = rf; done_v[i] = done; busy_v[i] = busy;
         miss_v[i] = trig_miss; wrap_v[i] = scan_wrap;
         if (i == 1) trig = 1'b0;
         if (i == extra) trig = 1'b1;
         if (i == extra + 2) trig = 1'b0;
      end
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_rf", rf, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_seq", seq_count, 0);
      chk("rst_len", cur_len, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("init_len", cur_len, 10);
      repeat (3) @(negedge clk);
      pi2_len = 10; pi_len = 20; gap_len = 20;
      shot(100, -1);
      chk("mz_rf", rf_v, rng(3, 12) | rng(33, 52) | rng(73, 82));
      chk("mz_done", done_v, rng(83, 83));
      chk("mz_busy", busy_v, rng(3, 82));
      chk("mz_miss", miss_v, 0);
      chk("mz_seq", seq_count, 1);
      shot(100, 5);
      chk("miss_rf", rf_v, rng(3, 12) | rng(33, 52) | rng(73, 82));
      chk("miss_done", done_v, rng(83, 83));
      chk("miss_pulse", miss_v, rng(9, 9));
      chk("miss_seq", seq_count, 2);
      pi2_len = 5; pi_len = 10; gap_len = 0;
      shot(40, -1);
      chk("merge_rf", rf_v, rng(3, 22));
      chk("merge_done", done_v, rng(23, 23));
      chk("merge_seq", seq_count, 3);
      pi2_len = 0; pi_len = 0; gap_len = 0;
      shot(20, -1);
      chk("zero_rf", rf_v, 0);
      chk("zero_done", done_v, rng(3, 3));
      chk("zero_seq", seq_count, 4);
      mode = 1'b1;
      shot(50, -1);
      chk("rabi1_rf", rf_v, rng(3, 12));
      chk("rabi1_done", done_v, rng(13, 13));
      chk("rabi1_wrap", wrap_v, 0);
      chk("rabi1_len", cur_len, 20);
      shot(50, -1);
      chk("rabi2_rf", rf_v, rng(3, 22));
      chk("rabi2_wrap", wrap_v, 0);
      chk("rabi2_len", cur_len, 30);
      shot(50, -1);
      chk("rabi3_rf", rf_v, rng(3, 32));
      chk("rabi3_wrap", wrap_v, rng(33, 33));
      chk("rabi3_len", cur_len, 10);
      shot(50, -1);
      chk("rabi4_rf", rf_v, rng(3, 12));
      chk("rabi4_wrap", wrap_v, 0);
      chk("rabi4_len", cur_len, 20);
      shot(50, -1);
      chk("rabi5_rf", rf_v, rng(3, 22));
      chk("rabi5_len", cur_len, 30);
      chk("rabi_seq", seq_count, 9);
      rabi_start = 15;
      scan_clr = 1'b1;
      @(negedge clk);
      scan_clr = 1'b0;
      chk("clr_len", cur_len, 15);
      rabi_start = 10;
      mode = 1'b0; pi2_len = 10; pi_len = 20; gap_len = 20;
      @(negedge clk);
      trig = 1'b1;
      repeat (2) @(negedge clk);
      trig = 1'b0;
      repeat (39) @(negedge clk);
      chk("pre_rst_rf", rf, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rf", rf, 0);
      chk("arst_busy", busy, 0);
      chk("arst_seq", seq_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rerst_len", cur_len, 10);
      shot(100, -1);
      chk("fresh_rf", rf_v, rng(3, 12) | rng(33, 52) | rng(73, 82));
      chk("fresh_done", done_v, rng(83, 83));
      chk("fresh_seq", seq_count, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
